// File: rtl/state_frame_streamer.sv
// Debug-state frame serialiser for the NT-hash cracker.
// Snapshots cracker state at frame start and streams a framed record set
// (5 records + footer) byte by byte over a valid/ready interface.
// Optional build macro: STATE_FRAME_CRC_EN appends a CRC-8 byte (poly 0x07).
module state_frame_streamer #(
    parameter int unsigned PW_CHARS   = 20,
    parameter int unsigned HASH_COUNT = 64,
    parameter int unsigned HASH_DUMP  = 2
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [4:0]                password_len,
    input  logic [8*PW_CHARS-1:0]     password_chars,
    input  logic [128*HASH_COUNT-1:0] hashes,
    input  logic [127:0]              current_hash,
    input  logic [4:0]                ntcrackfpga_state,
    input  logic [3:0]                hashchecker_state,
    input  logic [5:0]                md4block_step,
    input  logic                      cont_mode,
    input  logic                      trigger,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      frame_active,
    output logic                      frame_done
);
    // Byte offsets of each frame section
    localparam int OffPw   = 11;
    localparam int OffR3   = OffPw + int'(PW_CHARS);
    localparam int OffHash = OffR3 + 6;
    localparam int OffR4   = OffHash + 16 * int'(HASH_DUMP);
    localparam int OffR5   = OffR4 + 21;
    localparam int OffFoot = OffR5 + 8;
    localparam int BaseLen = OffFoot + 4;
`ifdef STATE_FRAME_CRC_EN
    localparam int FrameLen = BaseLen + 1;
`else
    localparam int FrameLen = BaseLen;
`endif
    localparam int unsigned IdxW = $clog2(FrameLen);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(FrameLen - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

    state_e                      state_q, state_d;
    logic [IdxW-1:0]             byte_q, byte_d;
    logic [7:0]                  win_q, win_d;
    logic                        pending_q, pending_d;
    logic                        done_q, done_d;
    logic [8:0]                  win_sum;
    logic                        pend_set;

    // Shadow copies taken in LOAD
    logic [4:0]                  pwlen_q;
    logic [8*PW_CHARS-1:0]       pw_q;
    logic [128*HASH_DUMP-1:0]    hw_q;
    logic [7:0]                  idx_sh_q;
    logic [127:0]                cur_q;
    logic [4:0]                  ntc_q;
    logic [3:0]                  hc_q;
    logic [5:0]                  md4_q;

    function automatic logic [7:0] hdr_byte(input int pos, input logic [7:0] id);
        case (pos)
            0:       return 8'h0A;
            1:       return 8'h55;
            2:       return 8'hFA;
            3:       return 8'hCE;
            default: return id;
        endcase
    endfunction

    function automatic logic [7:0] foot_byte(input int pos);
        case (pos)
            0:       return 8'hA2;
            1:       return 8'h5E;
            2:       return 8'hFA;
            default: return 8'hCE;
        endcase
    endfunction

`ifdef STATE_FRAME_CRC_EN
    logic [7:0] crc_q;

    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Running CRC over accepted bytes, cleared at frame load
    always_ff @(posedge clk) begin
        if (!nrst || state_q == StLoad) begin
            crc_q <= 8'h00;
        end else if (state_q == StSend && tx_ready) begin
            crc_q <= crc8_next(crc_q, tx_data);
        end
    end
`endif

    assign tx_valid     = (state_q == StSend);
    assign frame_active = (state_q != StIdle);
    assign frame_done   = done_q;

    // State, byte index, window index and pending-trigger registers
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= StIdle;
            byte_q    <= '0;
            win_q     <= 8'h00;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            win_q     <= win_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    // Snapshot all state inputs in LOAD so the frame is self-consistent
    always_ff @(posedge clk) begin
        if (state_q == StLoad) begin
            pwlen_q  <= password_len;
            pw_q     <= password_chars;
            cur_q    <= current_hash;
            ntc_q    <= ntcrackfpga_state;
            hc_q     <= hashchecker_state;
            md4_q    <= md4block_step;
            idx_sh_q <= win_q;
            for (int j = 0; j < int'(HASH_DUMP); j++) begin
                for (int k = 0; k < int'(HASH_COUNT); k++) begin
                    if (k == int'(win_q) + j) begin
                        hw_q[128*(int'(HASH_DUMP)-j)-1 -: 128] <=
                            hashes[128*(int'(HASH_COUNT)-k)-1 -: 128];
                    end
                end
            end
        end
    end

    // Next-state: frame sequencing, window rotation, pending trigger capture
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        win_d     = win_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        win_sum   = {1'b0, win_q} + 9'(HASH_DUMP);
        pend_set  = trigger && !cont_mode && (state_q != StIdle);
        if (pend_set) begin
            pending_d = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (trigger || cont_mode) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                byte_d  = '0;
                state_d = StSend;
            end
            StSend: begin
                if (tx_ready) begin
                    if (byte_q == LastIdx) begin
                        done_d    = 1'b1;
                        win_d     = (win_sum >= 9'(HASH_COUNT)) ? 8'h00 : win_sum[7:0];
                        // A trigger coinciding with the last byte counts as pending
                        state_d   = (cont_mode || pending_q || pend_set) ? StLoad : StIdle;
                        pending_d = 1'b0;
                    end else begin
                        byte_d = byte_q + IdxW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output byte mux from shadow registers, MSB-first within fields
    always_comb begin
        int b;
        tx_data = 8'h00;
        b = int'(byte_q);
        if (state_q == StSend) begin
            if (b < 5) begin
                tx_data = hdr_byte(b, 8'h01);
            end else if (b == 5) begin
                tx_data = {3'b000, pwlen_q};
            end else if (b < OffPw) begin
                tx_data = hdr_byte(b - 6, 8'h02);
            end else if (b < OffR3) begin
                for (int i = 0; i < int'(PW_CHARS); i++) begin
                    if (b - OffPw == i) tx_data = pw_q[8*(int'(PW_CHARS)-1-i) +: 8];
                end
            end else if (b < OffHash - 1) begin
                tx_data = hdr_byte(b - OffR3, 8'h03);
            end else if (b == OffHash - 1) begin
                tx_data = idx_sh_q;
            end else if (b < OffR4) begin
                for (int i = 0; i < 16 * int'(HASH_DUMP); i++) begin
                    if (b - OffHash == i) tx_data = hw_q[8*(16*int'(HASH_DUMP)-1-i) +: 8];
                end
            end else if (b < OffR4 + 5) begin
                tx_data = hdr_byte(b - OffR4, 8'h04);
            end else if (b < OffR5) begin
                for (int i = 0; i < 16; i++) begin
                    if (b - OffR4 - 5 == i) tx_data = cur_q[8*(15-i) +: 8];
                end
            end else if (b < OffR5 + 5) begin
                tx_data = hdr_byte(b - OffR5, 8'h05);
            end else if (b == OffR5 + 5) begin
                tx_data = {3'b000, ntc_q};
            end else if (b == OffR5 + 6) begin
                tx_data = {4'b0000, hc_q};
            end else if (b == OffR5 + 7) begin
                tx_data = {2'b00, md4_q};
            end else if (b < BaseLen) begin
                tx_data = foot_byte(b - OffFoot);
            end
`ifdef STATE_FRAME_CRC_EN
            else begin
                tx_data = crc_q;
            end
`endif
        end
    end

endmodule

// File: tb/tb_state_frame_streamer.sv
// Scoreboard bench for state_frame_streamer: stimulus pushes expected frames,
// a negedge monitor pops and compares every accepted byte and frame_done pulse.
module tb_state_frame_streamer;
    localparam int PwChars   = 20;
    localparam int HashCount = 64;
    localparam int HashDump  = 2;
`ifdef STATE_FRAME_CRC_EN
    localparam int  FrameLen = 103;
    localparam bit  CrcEn    = 1'b1;
`else
    localparam int  FrameLen = 102;
    localparam bit  CrcEn    = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     nrst = 1'b0;
    logic [4:0]               password_len;
    logic [8*PwChars-1:0]     password_chars;
    logic [128*HashCount-1:0] hashes;
    logic [127:0]             current_hash;
    logic [4:0]               ntcrackfpga_state;
    logic [3:0]               hashchecker_state;
    logic [5:0]               md4block_step;
    logic                     cont_mode;
    logic                     trigger;
    logic [7:0]               tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic                     frame_active;
    logic                     frame_done;

    state_frame_streamer #(
        .PW_CHARS  (PwChars),
        .HASH_COUNT(HashCount),
        .HASH_DUMP (HashDump)
    ) dut (
        .clk              (clk),
        .nrst             (nrst),
        .password_len     (password_len),
        .password_chars   (password_chars),
        .hashes           (hashes),
        .current_hash     (current_hash),
        .ntcrackfpga_state(ntcrackfpga_state),
        .hashchecker_state(hashchecker_state),
        .md4block_step    (md4block_step),
        .cont_mode        (cont_mode),
        .trigger          (trigger),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .frame_active     (frame_active),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         dut_cnt = 0;
    int         done_cnt = 0;
    int         win = 0;
    bit         mon_en = 1'b0;
    bit         rand_ready = 1'b0;
    bit         expect_done = 1'b0;
    bit         expect_start = 1'b0;
    bit         held_v = 1'b0;
    logic [7:0] held_d;
    logic [7:0] mcrc;

    localparam logic [127:0] CurA = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] CurB = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hbyte(input int k, input int n);
        return 8'((k * 7 + n * 13 + 1) & 255);
    endfunction

    function automatic logic [7:0] pwbyte(input int i);
        return 8'(97 + i);
    endfunction

    function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    task automatic push_b(input logic [7:0] d, input logic last);
        exp_t e;
        e.d    = d;
        e.last = last;
        exp_q.push_back(e);
        mcrc = crc8(mcrc, d);
    endtask

    task automatic push_hdr(input logic [7:0] id);
        push_b(8'h0A, 1'b0);
        push_b(8'h55, 1'b0);
        push_b(8'hFA, 1'b0);
        push_b(8'hCE, 1'b0);
        push_b(id, 1'b0);
    endtask

    // Expected frame from the values the bench drives; advances the window model
    task automatic push_frame(input logic [4:0] plen, input logic [127:0] cur);
        mcrc = 8'h00;
        push_hdr(8'h01);
        push_b({3'b000, plen}, 1'b0);
        push_hdr(8'h02);
        for (int i = 0; i < PwChars; i++) push_b(pwbyte(i), 1'b0);
        push_hdr(8'h03);
        push_b(8'(win), 1'b0);
        for (int j = 0; j < HashDump; j++)
            for (int n = 0; n < 16; n++) push_b(hbyte(win + j, n), 1'b0);
        push_hdr(8'h04);
        for (int n = 0; n < 16; n++) push_b(cur[127-8*n -: 8], 1'b0);
        push_hdr(8'h05);
        push_b({3'b000, ntcrackfpga_state}, 1'b0);
        push_b({4'b0000, hashchecker_state}, 1'b0);
        push_b({2'b00, md4block_step}, 1'b0);
        push_b(8'hA2, 1'b0);
        push_b(8'h5E, 1'b0);
        push_b(8'hFA, 1'b0);
        push_b(8'hCE, !CrcEn);
        if (CrcEn) push_b(mcrc, 1'b1);
        win = (win + HashDump) % HashCount;
    endtask

    task automatic pulse_trigger();
        @(posedge clk);
        #1 trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
        check("frames_done", done_cnt, target);
    endtask

    // Monitor: compares accepted bytes, frame_done timing and stall stability
    always @(negedge clk) begin
        exp_t e;
        if (!mon_en) begin
            held_v       = 1'b0;
            expect_done  = 1'b0;
            expect_start = 1'b0;
        end else begin
            if (expect_start) begin
                check("next_frame_start", tx_valid, 1);
                expect_start = 1'b0;
            end
            if (expect_done || frame_done) begin
                check("frame_done", frame_done, expect_done);
                if (expect_done) begin
                    check("valid_drop", tx_valid, 0);
                    if (exp_q.size() > 0) expect_start = 1'b1;
                end
            end
            if (frame_done) begin
                done_cnt++;
                check("frame_len", dut_cnt, FrameLen);
                dut_cnt = 0;
            end
            expect_done = 1'b0;
            if (held_v && tx_valid) check("stall_hold", tx_data, held_d);
            held_v = tx_valid && !tx_ready;
            held_d = tx_data;
            if (tx_valid && tx_ready) begin
                dut_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", tx_data, e.d);
                    if (e.last) expect_done = 1'b1;
                end
            end
        end
    end

    // Pseudo-random backpressure
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        int base;
        password_len      = 5'd7;
        current_hash      = CurA;
        ntcrackfpga_state = 5'h13;
        hashchecker_state = 4'h9;
        md4block_step     = 6'h2A;
        cont_mode         = 1'b0;
        trigger           = 1'b0;
        tx_ready          = 1'b1;
        for (int i = 0; i < PwChars; i++) password_chars[8*(PwChars-1-i) +: 8] = pwbyte(i);
        for (int k = 0; k < HashCount; k++)
            for (int n = 0; n < 16; n++) hashes[128*(HashCount-k)-1-8*n -: 8] = hbyte(k, n);

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_frame_active", frame_active, 0);
        check("rst_frame_done", frame_done, 0);
        nrst   = 1'b1;
        mon_en = 1'b1;

        // Single triggered frame at full throughput
        push_frame(5'd7, CurA);
        pulse_trigger();
        wait_frames(1, 400);
        repeat (5) @(negedge clk);
        check("idle_valid", tx_valid, 0);
        check("idle_active", frame_active, 0);

        // Random backpressure
        push_frame(5'd7, CurA);
        rand_ready = 1'b1;
        pulse_trigger();
        wait_frames(2, 2000);
        rand_ready = 1'b0;
        @(posedge clk);
        #2 tx_ready = 1'b1;

        // Inputs changed after LOAD do not affect the running frame
        push_frame(5'd7, CurA);
        pulse_trigger();
        for (int i = 0; i < 20 && !tx_valid; i++) @(negedge clk);
        password_len = 5'd12;
        current_hash = CurB;
        wait_frames(3, 400);
        push_frame(5'd12, CurB);
        pulse_trigger();
        wait_frames(4, 400);

        // Several triggers during one frame give exactly one follow-on frame
        push_frame(5'd12, CurB);
        push_frame(5'd12, CurB);
        pulse_trigger();
        for (int i = 0; i < 200 && dut_cnt < 10; i++) @(negedge clk);
        pulse_trigger();
        repeat (3) @(posedge clk);
        pulse_trigger();
        pulse_trigger();
        wait_frames(6, 600);
        repeat (10) @(negedge clk);
        check("no_extra_frame", done_cnt, 6);
        check("queue_after_trig", exp_q.size(), 0);

        // Continuous mode: 33 back-to-back frames, window wraps
        base = done_cnt;
        for (int f = 0; f < 33; f++) push_frame(5'd12, CurB);
        @(posedge clk);
        #1 cont_mode = 1'b1;
        wait_frames(base + 32, 33 * 150);
        cont_mode = 1'b0;
        wait_frames(base + 33, 300);
        repeat (10) @(negedge clk);
        check("cont_stop", done_cnt, base + 33);
        check("cont_idle", tx_valid, 0);

        // Reset mid-frame aborts; next frame restarts with window 0
        push_frame(5'd12, CurB);
        pulse_trigger();
        for (int i = 0; i < 300 && dut_cnt < 50; i++) @(negedge clk);
        mon_en = 1'b0;
        nrst   = 1'b0;
        @(posedge clk);
        #1;
        check("reset_valid", tx_valid, 0);
        check("reset_active", frame_active, 0);
        nrst = 1'b1;
        exp_q.delete();
        dut_cnt = 0;
        win     = 0;
        mon_en  = 1'b1;
        base    = done_cnt;
        push_frame(5'd12, CurB);
        pulse_trigger();
        wait_frames(base + 1, 400);
        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
